// File: rtl/text_grid.sv
// Character grid fed one byte at a time from a UART, with control-code handling
// and a compile-time end-of-screen policy (wrap, scroll or hold).
module text_grid #(
    parameter int COLS = 16,
    parameter int ROWS = 4,
    parameter int MODE = 0,
    parameter logic [7:0] FILL = 8'h20,
    localparam int CW = $clog2(COLS),
    localparam int RW = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              byteReady,
    input  logic [7:0]        data,
    input  logic [CW-1:0]     readCol,
    output logic [ROWS*8-1:0] rowBytes,
    output logic [RW-1:0]     cursorRow,
    output logic [CW-1:0]     cursorCol,
    output logic              full,
    output logic              updated
);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    typedef enum logic [1:0] {WAIT_LOW, WAIT_HIGH, APPLY} state_t;

    state_t        stateReg, stateNext;
    logic [7:0]    byteReg;
    logic [RW-1:0] rowReg, rowNext;
    logic [CW-1:0] colReg, colNext;
    logic          fullReg, fullNext;
    logic          updReg, updNext;
    logic          doWrite, doScroll, doClear;
    logic [RW-1:0] wRow;
    logic [CW-1:0] wCol;
    logic [7:0]    wVal;
    logic          lastRow, lastCol, isPrint, colValid;

    logic [7:0] cells    [ROWS][COLS];
    logic [7:0] written  [ROWS][COLS];
    logic [7:0] nextCell [ROWS][COLS];

    assign lastRow = (rowReg == LAST_ROW);
    assign lastCol = (colReg == LAST_COL);
    assign isPrint = (byteReg >= 8'h20) && (byteReg <= 8'h7E);

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            WAIT_LOW:  if (!byteReady) stateNext = WAIT_HIGH;
            WAIT_HIGH: if (byteReady)  stateNext = APPLY;
            default:   stateNext = WAIT_LOW;
        endcase
    end

    always_comb begin
        rowNext  = rowReg;
        colNext  = colReg;
        fullNext = fullReg;
        updNext  = 1'b0;
        doWrite  = 1'b0;
        doScroll = 1'b0;
        doClear  = 1'b0;
        wRow     = rowReg;
        wCol     = colReg;
        wVal     = byteReg;
        if (stateReg == APPLY) begin
            if (isPrint) begin
                if (!fullReg) begin
                    doWrite = 1'b1;
                    updNext = 1'b1;
                    if (!lastCol) begin
                        colNext = colReg + 1'b1;
                    end else if (!lastRow) begin
                        colNext = '0;
                        rowNext = rowReg + 1'b1;
                    end else if (MODE == 1) begin
                        doScroll = 1'b1;
                        colNext  = '0;
                    end else if (MODE == 2) begin
                        fullNext = 1'b1;
                    end else begin
                        colNext = '0;
                        rowNext = '0;
                    end
                end
            end else begin
                case (byteReg)
                    8'h0A: begin
                        if (!fullReg && !(MODE == 2 && lastRow)) begin
                            updNext = 1'b1;
                            colNext = '0;
                            if (!lastRow)       rowNext = rowReg + 1'b1;
                            else if (MODE == 1) doScroll = 1'b1;
                            else                rowNext = '0;
                        end
                    end
                    8'h0D: begin
                        colNext = '0;
                        updNext = (colReg != '0);
                    end
                    8'h08: begin
                        // While full the cursor already sits on the last cell: erase it in place.
                        if (fullReg) begin
                            doWrite  = 1'b1;
                            wVal     = FILL;
                            fullNext = 1'b0;
                            updNext  = 1'b1;
                        end else if (rowReg != '0 || colReg != '0) begin
                            doWrite = 1'b1;
                            wVal    = FILL;
                            updNext = 1'b1;
                            if (colReg != '0) begin
                                colNext = colReg - 1'b1;
                            end else begin
                                colNext = LAST_COL;
                                rowNext = rowReg - 1'b1;
                            end
                            wRow = rowNext;
                            wCol = colNext;
                        end
                    end
                    8'h0C: begin
                        doClear  = 1'b1;
                        rowNext  = '0;
                        colNext  = '0;
                        fullNext = 1'b0;
                        updNext  = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // The write is folded in before the scroll so a byte landing on the last cell moves up with its row.
    for (genvar gi = 0; gi < ROWS; gi++) begin : gRow
        for (genvar gj = 0; gj < COLS; gj++) begin : gCol
            assign written[gi][gj] = (doWrite && wRow == RW'(gi) && wCol == CW'(gj)) ? wVal : cells[gi][gj];
            if (gi == ROWS - 1) begin : gLast
                assign nextCell[gi][gj] = (doClear || doScroll) ? FILL : written[gi][gj];
            end else begin : gInner
                assign nextCell[gi][gj] = doClear  ? FILL :
                                          doScroll ? written[gi+1][gj] : written[gi][gj];
            end
        end
        assign rowBytes[gi*8 +: 8] = colValid ? cells[gi][readCol] : FILL;
    end

    assign colValid = ({1'b0, readCol} < (CW + 1)'(COLS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    cells[r][c] <= FILL;
        end else begin
            cells <= nextCell;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= WAIT_LOW;
            byteReg  <= 8'h00;
            rowReg   <= '0;
            colReg   <= '0;
            fullReg  <= 1'b0;
            updReg   <= 1'b0;
        end else begin
            stateReg <= stateNext;
            if (stateReg == WAIT_HIGH && byteReady) byteReg <= data;
            rowReg   <= rowNext;
            colReg   <= colNext;
            fullReg  <= fullNext;
            updReg   <= updNext;
        end
    end

    assign cursorRow = rowReg;
    assign cursorCol = colReg;
    assign full      = fullReg;
    assign updated   = updReg;
endmodule

// File: tb/tb_text_grid.sv
// Directed bench for text_grid: one instance per end-of-screen policy (wrap, scroll, hold),
// table-driven control-code vectors plus hand sequences for the screen-edge cases.
module tb_text_grid;
    localparam int COLS = 16;
    localparam int ROWS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        br   [3];
    logic [7:0]  dat  [3];
    logic [3:0]  rc   [3];
    logic [31:0] rb   [3];
    logic [1:0]  crow [3];
    logic [3:0]  ccol [3];
    logic        fullS[3];
    logic        upd  [3];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    text_grid #(.COLS(COLS), .ROWS(ROWS), .MODE(0)) u0 (
        .clk(clk), .reset(reset), .byteReady(br[0]), .data(dat[0]), .readCol(rc[0]),
        .rowBytes(rb[0]), .cursorRow(crow[0]), .cursorCol(ccol[0]), .full(fullS[0]), .updated(upd[0]));
    text_grid #(.COLS(COLS), .ROWS(ROWS), .MODE(1)) u1 (
        .clk(clk), .reset(reset), .byteReady(br[1]), .data(dat[1]), .readCol(rc[1]),
        .rowBytes(rb[1]), .cursorRow(crow[1]), .cursorCol(ccol[1]), .full(fullS[1]), .updated(upd[1]));
    text_grid #(.COLS(COLS), .ROWS(ROWS), .MODE(2)) u2 (
        .clk(clk), .reset(reset), .byteReady(br[2]), .data(dat[2]), .readCol(rc[2]),
        .rowBytes(rb[2]), .cursorRow(crow[2]), .cursorCol(ccol[2]), .full(fullS[2]), .updated(upd[2]));

    typedef struct {
        logic [7:0] b;
        int         eRow;
        int         eCol;
        logic       eUpd;
        int         cRow;
        int         cCol;
        logic [7:0] cVal;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkCell(input string name, input int u, input int r, input int c, input logic [7:0] exp);
        logic [31:0] row;
        rc[u] = 4'(c);
        #1;
        row = rb[u];
        check($sformatf("%s_cell%0d_%0d", name, r, c), 32'(row[r*8 +: 8]), 32'(exp));
    endtask

    task automatic checkCursor(input string name, input int u, input int r, input int c);
        check({name, "_row"}, 32'(crow[u]), 32'(r));
        check({name, "_col"}, 32'(ccol[u]), 32'(c));
    endtask

    // One full handshake: raise, hold one cycle, drop, then sample updated after the apply edge.
    task automatic sendByte(input int u, input logic [7:0] b, output logic updSeen);
        @(posedge clk);
        #1;
        br[u]  = 1'b1;
        dat[u] = b;
        @(posedge clk);
        #1;
        br[u] = 1'b0;
        @(posedge clk);
        #1;
        updSeen = upd[u];
    endtask

    task automatic doReset();
        reset = 1'b1;
        for (int u = 0; u < 3; u++) begin
            br[u]  = 1'b0;
            dat[u] = 8'h00;
            rc[u]  = 4'd0;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic  us;
        string s;
        string rowStr;
        logic [7:0] expB;

        tbl[0]  = '{8'h41, 0,  1, 1'b1, 0,  0, 8'h41};
        tbl[1]  = '{8'h42, 0,  2, 1'b1, 0,  1, 8'h42};
        tbl[2]  = '{8'h01, 0,  2, 1'b0, 0,  2, 8'h20};
        tbl[3]  = '{8'h0D, 0,  0, 1'b1, 0,  1, 8'h42};
        tbl[4]  = '{8'h43, 0,  1, 1'b1, 0,  0, 8'h43};
        tbl[5]  = '{8'h0A, 1,  0, 1'b1, 0,  0, 8'h43};
        tbl[6]  = '{8'h44, 1,  1, 1'b1, 1,  0, 8'h44};
        tbl[7]  = '{8'h08, 1,  0, 1'b1, 1,  0, 8'h20};
        tbl[8]  = '{8'h08, 0, 15, 1'b1, 0, 15, 8'h20};
        tbl[9]  = '{8'h0C, 0,  0, 1'b1, 0,  1, 8'h20};
        tbl[10] = '{8'h08, 0,  0, 1'b0, 0,  0, 8'h20};

        // Reset state
        doReset();
        checkCursor("reset", 0, 0, 0);
        check("reset_full", 32'(fullS[0]), 0);
        check("reset_upd", 32'(upd[0]), 0);
        checkCell("reset", 0, 0, 0, 8'h20);

        // Control-code table on the wrap instance
        for (int i = 0; i < 11; i++) begin
            sendByte(0, tbl[i].b, us);
            check($sformatf("vec%0d_upd", i), 32'(us), 32'(tbl[i].eUpd));
            checkCursor($sformatf("vec%0d", i), 0, tbl[i].eRow, tbl[i].eCol);
            checkCell($sformatf("vec%0d", i), 0, tbl[i].cRow, tbl[i].cCol, tbl[i].cVal);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_updlow", i), 32'(upd[0]), 0);
        end

        // byteReady held high through reset release must not be taken
        reset  = 1'b1;
        br[0]  = 1'b1;
        dat[0] = 8'h41;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("held_upd", 32'(upd[0]), 0);
        checkCursor("held", 0, 0, 0);
        checkCell("held", 0, 0, 0, 8'h20);
        br[0] = 1'b0;
        sendByte(0, 8'h41, us);
        check("held_after_upd", 32'(us), 1);
        checkCell("held_after", 0, 0, 0, 8'h41);
        checkCursor("held_after", 0, 0, 1);

        // WRAP: 64 'x' wrap the cursor to (0,0), the 65th overwrites (0,0)
        doReset();
        for (int i = 0; i < 64; i++) sendByte(0, 8'h78, us);
        checkCursor("wrap64", 0, 0, 0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                checkCell("wrap64", 0, r, c, 8'h78);
        sendByte(0, 8'h77, us);
        checkCursor("wrap65", 0, 0, 1);
        checkCell("wrap65", 0, 0, 0, 8'h77);
        checkCell("wrap65", 0, 0, 1, 8'h78);
        check("wrap_full", 32'(fullS[0]), 0);

        // SCROLL: four lines plus newline on the last row push everything up
        doReset();
        s = "row0\nrow1\nrow2\nrow3";
        for (int i = 0; i < s.len(); i++) sendByte(1, s[i], us);
        checkCursor("scroll_pre", 1, 3, 4);
        sendByte(1, 8'h0A, us);
        check("scroll_upd", 32'(us), 1);
        checkCursor("scroll", 1, 3, 0);
        rowStr = "row";
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (c < 3)       expB = rowStr[c];
                else if (c == 3) expB = 8'(8'h31 + r);
                else             expB = 8'h20;
                checkCell("scroll", 1, r, c, expB);
            end
        end
        for (int c = 0; c < COLS; c++) checkCell("scroll_last", 1, 3, c, 8'h20);

        // HOLD: last cell sets full, later bytes dropped, backspace erases it
        doReset();
        for (int i = 0; i < 63; i++) sendByte(2, 8'h78, us);
        checkCursor("hold63", 2, 3, 15);
        check("hold63_full", 32'(fullS[2]), 0);
        sendByte(2, 8'h78, us);
        check("hold64_full", 32'(fullS[2]), 1);
        checkCursor("hold64", 2, 3, 15);
        checkCell("hold64", 2, 3, 15, 8'h78);
        sendByte(2, 8'h79, us);
        check("hold_y_upd", 32'(us), 0);
        checkCell("hold_y", 2, 3, 15, 8'h78);
        sendByte(2, 8'h0A, us);
        check("hold_nl_upd", 32'(us), 0);
        checkCursor("hold_nl", 2, 3, 15);
        sendByte(2, 8'h08, us);
        check("hold_bs_upd", 32'(us), 1);
        check("hold_bs_full", 32'(fullS[2]), 0);
        checkCursor("hold_bs", 2, 3, 15);
        checkCell("hold_bs", 2, 3, 15, 8'h20);
        checkCell("hold_bs", 2, 3, 14, 8'h78);
        sendByte(2, 8'h79, us);
        check("hold_refill_full", 32'(fullS[2]), 1);
        checkCell("hold_refill", 2, 3, 15, 8'h79);

        // Backspace to origin, no-op backspace, then form feed clears everything
        doReset();
        sendByte(0, 8'h51, us);
        checkCursor("q", 0, 0, 1);
        sendByte(0, 8'h08, us);
        check("q_bs_upd", 32'(us), 1);
        checkCursor("q_bs", 0, 0, 0);
        checkCell("q_bs", 0, 0, 0, 8'h20);
        sendByte(0, 8'h08, us);
        check("q_bs2_upd", 32'(us), 0);
        checkCursor("q_bs2", 0, 0, 0);
        sendByte(0, 8'h5A, us);
        sendByte(0, 8'h0A, us);
        sendByte(0, 8'h4B, us);
        checkCell("q_pre_ff", 0, 1, 0, 8'h4B);
        sendByte(0, 8'h0C, us);
        check("ff_upd", 32'(us), 1);
        checkCursor("ff", 0, 0, 0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                checkCell("ff", 0, r, c, 8'h20);

        // Reset asserted while a latched byte waits in APPLY
        sendByte(0, 8'h41, us);
        checkCell("pre_rst", 0, 0, 0, 8'h41);
        @(posedge clk);
        #1;
        br[0]  = 1'b1;
        dat[0] = 8'h52;
        @(posedge clk);
        #1;
        reset = 1'b1;
        br[0] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_apply_upd", 32'(upd[0]), 0);
        checkCursor("rst_apply", 0, 0, 0);
        checkCell("rst_apply", 0, 0, 0, 8'h20);
        repeat (3) @(posedge clk);
        #1;
        check("rst_apply_late_upd", 32'(upd[0]), 0);
        checkCell("rst_apply_late", 0, 0, 0, 8'h20);
        checkCell("rst_apply_late", 0, 0, 1, 8'h20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/text_grid.md
# text_grid

Parametrised character buffer for the UART-to-display path. It accepts one byte per `byteReady` pulse and writes it into a `ROWS` x `COLS` grid at a write cursor. It handles newline, carriage return, backspace and form feed, and applies a selectable end-of-screen policy: wrap, scroll or hold. The display scanner reads one column of every row at once through `readCol`.

## Interface
Parameters:
- `COLS`, 16: characters per row, ≥2.
- `ROWS`, 4: number of rows, ≥2.
- `MODE`, 0: end-of-screen policy. 0 = WRAP, 1 = SCROLL, 2 = HOLD.
- `FILL`, 8'h20: blank character used for reset, clear and erase.

Ports (`CW` = `$clog2(COLS)`, `RW` = `$clog2(ROWS)`):
- `clk`  in  1: the only clock. All state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `byteReady`  in  1: byte strobe from the UART receiver.
- `data`  in  8: byte, valid while `byteReady`=1.
- `readCol`  in  CW: column selected for readout.
- `rowBytes`  out  ROWS*8: row r at `[r*8 +: 8]`, equal to cell (r, `readCol`). Combinational from the grid.
- `cursorRow`  out  RW: registered write cursor row.
- `cursorCol`  out  CW: registered write cursor column.
- `full`  out  1: HOLD only. Last cell written, further writes dropped.
- `updated`  out  1: one-cycle pulse after any grid or cursor change.

## Operation
Handshake FSM, states WAIT_LOW, WAIT_HIGH, APPLY:
- WAIT_LOW: if `byteReady`=0, go to WAIT_HIGH.
- WAIT_HIGH: if `byteReady`=1, latch `data` and go to APPLY.
- APPLY: execute the latched byte, then go to WAIT_LOW unconditionally.
- A `byteReady` held high out of reset is not accepted until it has been seen low.

Action for byte b in APPLY:
- Printable (0x20..0x7E):
  - Write b at the cursor, then advance.
  - Advance: col+1. At col=COLS-1: col=0, row+1. At the last cell the end-of-screen rule applies.
- 0x0A newline: col=0, row+1. On the last row the end-of-screen rule applies.
- 0x0D carriage return: col=0.
- 0x08 backspace:
  - At (0,0) and not full: no-op.
  - Otherwise step the cursor back one cell (crossing to col COLS-1 of the previous row) and write FILL there.
  - When `full`=1: write FILL at the last cell, clear `full`, cursor unchanged.
- 0x0C form feed: every cell to FILL, cursor (0,0), `full`=0.
- Any other byte: ignored. No change, no `updated` pulse.

End-of-screen rule (advance past row ROWS-1):
- WRAP: cursor (0,0). Content untouched.
- SCROLL: rows 1..ROWS-1 move to 0..ROWS-2, row ROWS-1 is filled with FILL, cursor (ROWS-1,0). All in the same cycle.
- HOLD: a printable byte at the last cell is written, the cursor stays at (ROWS-1,COLS-1) and `full` is set. A newline on the last row is dropped. While `full`=1, printable bytes and newline are dropped with no `updated` pulse.

Width and range rules:
- `readCol` ≥ COLS returns FILL on every row.
- Cursor values never exceed COLS-1 or ROWS-1.

## Timing
- Reset values:
  - Every cell = FILL.
  - `cursorRow` = 0, `cursorCol` = 0.
  - `full` = 0, `updated` = 0.
  - State = WAIT_LOW, latched byte cleared.
- `reset` mid-operation: immediate return to reset values. A byte in WAIT_HIGH or APPLY is discarded.
- Latency:
  - Edge E0 samples `byteReady`=1 in WAIT_HIGH and latches `data`.
  - Edge E1 (APPLY) updates grid, cursor and `full`.
  - `rowBytes` reflects the change after E1. `updated` is high for exactly the cycle after E1.
- Throughput: at most one byte per 3 cycles. `byteReady` must be low for at least 1 cycle and high for at least 1 cycle per byte.
- `rowBytes` follows `readCol` combinationally in the same cycle.

## Test plan
- Reset, send "AB" with COLS=16, ROWS=4: cell (0,0)=0x41 and (0,1)=0x42, cursor (0,2), two `updated` pulses, each 2 cycles after the `byteReady` rise.
- Hold `byteReady`=1 through the reset release with `data`=0x41: no write until `byteReady` falls and rises again.
- MODE=0, send 65 'x': all 64 cells hold 'x', the 65th overwrites (0,0), cursor (0,1).
- MODE=1, fill 4 rows using "row0\n"…"row3\n": after the last newline rows 0..2 read "row1","row2","row3", row 3 is all 0x20, cursor (3,0).
- MODE=2, send 64 'x' then 'y': `full`=1, 'y' dropped with no `updated` pulse. Backspace: cell (3,15)=0x20, `full`=0.
- Send 'Q', backspace at (0,0) with the cursor at (0,1), then form feed: the backspace erases (0,0) and moves the cursor to (0,0), a second backspace is a no-op, and the form feed blanks every cell. Assert `reset` during APPLY: the grid is cleared and no write occurs.
